threshold_frame_ctrl: RTL and testbench
=======================================

# threshold_frame_ctrl

Frame-level controller for the Canny double-thresholding stage. Holds the runtime-programmable high/low thresholds in shadow registers and commits them to the thresholding datapath only at start of frame, so thresholds never change mid-frame. Gates NMS pixel validity into the thresholder only while a frame is active, counts classified pixels, and reports per-frame strong/weak edge totals with a done pulse. Sits between the host configuration path, the NMS stage output and the double-thresholding datapath.

## Interface

- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- DEF_T_HIGH, 40, reset value of high threshold
- DEF_T_LOW, 20, reset value of low threshold
- CNT_W, 20, width of pixel/edge counters; must satisfy 2^CNT_W > IMG_W*IMG_H

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  one-cycle write strobe for new thresholds
- cfg_t_low  in  11  requested low threshold
- cfg_t_high  in  11  requested high threshold
- cfg_err  out  1  one-cycle pulse: write rejected
- sof  in  1  start-of-frame pulse
- sof_err  out  1  one-cycle pulse: sof arrived while busy
- nms_valid  in  1  pixel valid from NMS stage
- pix_valid  out  1  gated valid to thresholder
- t_low  out  11  active low threshold to thresholder
- t_high  out  11  active high threshold to thresholder
- strength  in  2  classification from thresholder (00 discard, 01 strong, 10 weak)
- strength_valid  in  1  classification valid
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame
- strong_count  out  CNT_W  strong edges in last completed frame
- weak_count  out  CNT_W  weak edges in last completed frame

## Operation

- States: IDLE, ACTIVE, DONE.
- IDLE: sof -> copy shadow thresholds to t_low/t_high, clear pixel/strong/weak working counters, go ACTIVE.
- ACTIVE: each strength_valid increments pixel counter; strength 01 increments strong, 10 increments weak, 00 and 11 count as pixels only. On strength_valid with pixel counter = IMG_W*IMG_H-1 -> go DONE.
- DONE (exactly one cycle): frame_done=1; strong_count/weak_count loaded from working counters including the final pixel; -> IDLE.
- pix_valid = nms_valid AND (state == ACTIVE); combinational.
- strength_valid outside ACTIVE is ignored (no count change).
- Config: cfg_wr with cfg_t_low <= cfg_t_high updates shadow registers next cycle, any state. cfg_t_low > cfg_t_high: shadow unchanged, cfg_err pulses next cycle. Equal values accepted.
- cfg_wr and sof in the same IDLE cycle: active thresholds take the old shadow; new values apply from the next frame.
- sof in ACTIVE or DONE: ignored for control, sof_err pulses next cycle; counting continues.
- Active t_low/t_high are constant from sof commit to next sof commit.
- Counters are CNT_W bits; no wrap possible given the parameter constraint.

## Timing

- Reset values: state IDLE; t_high=DEF_T_HIGH, t_low=DEF_T_LOW; shadows same; working counters, strong_count, weak_count = 0; busy, frame_done, cfg_err, sof_err = 0.
- Reset asserted mid-frame: immediate return to reset values; partial frame discarded, strong_count/weak_count cleared.
- sof at cycle N in IDLE: t_low/t_high updated and busy=1 from N+1; pix_valid can assert from N+1.
- busy = 1 in ACTIVE and DONE; drops the cycle after frame_done.
- Final pixel's strength_valid at cycle M: frame_done=1 at M+1, counts valid at M+1 and held until next DONE.
- Next sof accepted at M+2 at the earliest; sof at M+1 (DONE) raises sof_err.
- Thresholder is combinational: strength_valid arrives the same cycle as pix_valid; no extra pipeline assumed.

## Test plan

- Reset defaults: release rst_n -> t_high=40, t_low=20, busy=0, counts 0, no pulses.
- Full frame, IMG_W=4, IMG_H=2: sof, then 8 strength_valid with strengths 01,01,10,00,11,10,01,00 -> frame_done once, one cycle after 8th pixel; strong_count=3, weak_count=2; busy low next cycle.
- Config commit: write low=30/high=60 mid-frame -> t_low/t_high stay 20/40 until next sof, then 30/60 the cycle after sof.
- Invalid config: write low=50/high=10 -> cfg_err pulse, next frame still uses previous thresholds; write low=high=25 -> accepted.
- Gating and stray events: nms_valid high in IDLE -> pix_valid=0; strength_valid in IDLE -> no count change; sof during ACTIVE -> sof_err pulse, frame completes at original pixel count.
- Reset mid-frame after 5 pixels -> counts 0, state IDLE; new sof then 8 pixels completes a normal frame.

Source files
------------

// File: rtl/threshold_frame_ctrl.sv
// threshold_frame_ctrl: frame-level control for Canny double thresholding.
// Holds the host-programmed thresholds in shadow registers and commits them
// to the datapath only at start of frame. Gates NMS pixel validity while a
// frame is active, and counts classified pixels and strong/weak edges.
// At the end of each frame it reports the totals with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_wr, cfg_t_low/high       threshold write strobe and values
//   cfg_err                      pulse: rejected write (low > high)
//   sof, sof_err                 start of frame; pulse when sof arrives while busy
//   nms_valid, pix_valid         NMS pixel valid in; gated valid out (combinational)
//   t_low, t_high                active thresholds to the thresholder
//   strength, strength_valid     classification result from the thresholder
//   busy, frame_done             frame in progress; end-of-frame pulse
//   strong_count, weak_count     edge totals of the last completed frame
module threshold_frame_ctrl #(
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter int unsigned DEF_T_HIGH = 40,
    parameter int unsigned DEF_T_LOW  = 20,
    parameter int unsigned CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [10:0]      cfg_t_low,
    input  logic [10:0]      cfg_t_high,
    output logic             cfg_err,
    input  logic             sof,
    output logic             sof_err,
    input  logic             nms_valid,
    output logic             pix_valid,
    output logic [10:0]      t_low,
    output logic [10:0]      t_high,
    input  logic [1:0]       strength,
    input  logic             strength_valid,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] strong_count,
    output logic [CNT_W-1:0] weak_count
);

    localparam int unsigned TH_W      = 11;
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);
    localparam logic [TH_W-1:0]  RST_HIGH = TH_W'(DEF_T_HIGH);
    localparam logic [TH_W-1:0]  RST_LOW  = TH_W'(DEF_T_LOW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TH_W-1:0]   shadow_low_q, shadow_low_d;
    logic [TH_W-1:0]   shadow_high_q, shadow_high_d;
    logic [TH_W-1:0]   t_low_d, t_high_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  strong_cnt_q, strong_cnt_d;
    logic [CNT_W-1:0]  weak_cnt_q, weak_cnt_d;
    logic [CNT_W-1:0]  strong_count_d, weak_count_d;
    logic              cfg_err_d, sof_err_d, busy_d, frame_done_d;
    logic              cfg_ok;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d        = state_q;
        shadow_low_d   = shadow_low_q;
        shadow_high_d  = shadow_high_q;
        t_low_d        = t_low;
        t_high_d       = t_high;
        pix_cnt_d      = pix_cnt_q;
        strong_cnt_d   = strong_cnt_q;
        weak_cnt_d     = weak_cnt_q;
        strong_count_d = strong_count;
        weak_count_d   = weak_count;
        sof_err_d      = 1'b0;

        // Host writes land in the shadow in any state; equal values are legal
        cfg_ok    = cfg_wr && (cfg_t_low <= cfg_t_high);
        cfg_err_d = cfg_wr && !cfg_ok;
        if (cfg_ok) begin
            shadow_low_d  = cfg_t_low;
            shadow_high_d = cfg_t_high;
        end

        case (state_q)
            IDLE: begin
                if (sof) begin
                    // Commit the pre-write shadow so a same-cycle write waits a frame
                    t_low_d      = shadow_low_q;
                    t_high_d     = shadow_high_q;
                    pix_cnt_d    = '0;
                    strong_cnt_d = '0;
                    weak_cnt_d   = '0;
                    state_d      = ACTIVE;
                end
            end
            ACTIVE: begin
                sof_err_d = sof;
                if (strength_valid) begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (strength == 2'b01) begin
                        strong_cnt_d = strong_cnt_q + CNT_W'(1);
                    end
                    if (strength == 2'b10) begin
                        weak_cnt_d = weak_cnt_q + CNT_W'(1);
                    end
                    if (pix_cnt_q == LAST_PIX) begin
                        // Totals include the final pixel and are visible with frame_done
                        strong_count_d = strong_cnt_d;
                        weak_count_d   = weak_cnt_d;
                        state_d        = DONE;
                    end
                end
            end
            DONE: begin
                sof_err_d = sof;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_low_q  <= RST_LOW;
            shadow_high_q <= RST_HIGH;
            t_low         <= RST_LOW;
            t_high        <= RST_HIGH;
            pix_cnt_q     <= '0;
            strong_cnt_q  <= '0;
            weak_cnt_q    <= '0;
            strong_count  <= '0;
            weak_count    <= '0;
            cfg_err       <= 1'b0;
            sof_err       <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            shadow_low_q  <= shadow_low_d;
            shadow_high_q <= shadow_high_d;
            t_low         <= t_low_d;
            t_high        <= t_high_d;
            pix_cnt_q     <= pix_cnt_d;
            strong_cnt_q  <= strong_cnt_d;
            weak_cnt_q    <= weak_cnt_d;
            strong_count  <= strong_count_d;
            weak_count    <= weak_count_d;
            cfg_err       <= cfg_err_d;
            sof_err       <= sof_err_d;
            busy          <= busy_d;
            frame_done    <= frame_done_d;
        end
    end

    // Thresholder sees pixels only inside a frame
    assign pix_valid = nms_valid && (state_q == ACTIVE);

endmodule

// File: tb/tb_threshold_frame_ctrl.sv
// Directed bench for threshold_frame_ctrl on a 4x2 frame.
module tb_threshold_frame_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cfg_wr;
    logic [10:0]      cfg_t_low;
    logic [10:0]      cfg_t_high;
    logic             cfg_err;
    logic             sof;
    logic             sof_err;
    logic             nms_valid;
    logic             pix_valid;
    logic [10:0]      t_low;
    logic [10:0]      t_high;
    logic [1:0]       strength;
    logic             strength_valid;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] strong_count;
    logic [CNT_W-1:0] weak_count;

    int n_tests = 0;
    int n_fail  = 0;

    threshold_frame_ctrl #(
        .IMG_W(4), .IMG_H(2), .DEF_T_HIGH(40), .DEF_T_LOW(20), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr(cfg_wr), .cfg_t_low(cfg_t_low), .cfg_t_high(cfg_t_high),
        .cfg_err(cfg_err),
        .sof(sof), .sof_err(sof_err),
        .nms_valid(nms_valid), .pix_valid(pix_valid),
        .t_low(t_low), .t_high(t_high),
        .strength(strength), .strength_valid(strength_valid),
        .busy(busy), .frame_done(frame_done),
        .strong_count(strong_count), .weak_count(weak_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send n classified pixels; pixel i strength is p[2i+1:2i]
    task automatic send_pixels(input logic [15:0] p, input int n, input int first);
        for (int i = first; i < first + n; i++) begin
            nms_valid      = 1'b1;
            strength_valid = 1'b1;
            strength       = p[2*i +: 2];
            tick();
        end
        nms_valid      = 1'b0;
        strength_valid = 1'b0;
        strength       = 2'b00;
    endtask

    task automatic start_frame();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic write_cfg(input int lo, input int hi);
        cfg_wr     = 1'b1;
        cfg_t_low  = 11'(lo);
        cfg_t_high = 11'(hi);
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_t_low = '0; cfg_t_high = '0;
        sof = 1'b0; nms_valid = 1'b0; strength = 2'b00; strength_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset defaults
        check("rst_t_high", 32'(t_high), 40);
        check("rst_t_low", 32'(t_low), 20);
        check("rst_busy", 32'(busy), 0);
        check("rst_strong", 32'(strong_count), 0);
        check("rst_weak", 32'(weak_count), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_pulses", 32'({cfg_err, sof_err}), 0);

        // Gating and strays in IDLE
        nms_valid = 1'b1;
        #1;
        check("idle_pix_valid", 32'(pix_valid), 0);
        strength_valid = 1'b1; strength = 2'b01;
        tick();
        nms_valid = 1'b0; strength_valid = 1'b0;
        check("idle_sv_busy", 32'(busy), 0);
        check("idle_sv_strong", 32'(strong_count), 0);

        // Full frame: 01,01,10,00,11,10,01,00 -> strong 3, weak 2
        start_frame();
        check("f1_busy", 32'(busy), 1);
        check("f1_t_low", 32'(t_low), 20);
        check("f1_t_high", 32'(t_high), 40);
        nms_valid = 1'b1;
        #1;
        check("f1_pix_valid", 32'(pix_valid), 1);
        send_pixels(16'b00_01_10_11_00_10_01_01, 7, 0);
        check("f1_early_done", 32'(frame_done), 0);
        send_pixels(16'b00_01_10_11_00_10_01_01, 1, 7);
        check("f1_done", 32'(frame_done), 1);
        check("f1_strong", 32'(strong_count), 3);
        check("f1_weak", 32'(weak_count), 2);
        check("f1_busy_done", 32'(busy), 1);
        tick();
        check("f1_done_once", 32'(frame_done), 0);
        check("f1_busy_low", 32'(busy), 0);
        check("f1_strong_hold", 32'(strong_count), 3);

        // Mid-frame config write and stray sof
        start_frame();
        write_cfg(30, 60);
        check("f2_cfg_err", 32'(cfg_err), 0);
        check("f2_t_low_hold", 32'(t_low), 20);
        check("f2_t_high_hold", 32'(t_high), 40);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("f2_sof_err", 32'(sof_err), 1);
        check("f2_busy", 32'(busy), 1);
        tick();
        check("f2_sof_err_clr", 32'(sof_err), 0);
        send_pixels(16'b11_00_00_00_01_10_10_10, 7, 0);
        check("f2_early_done", 32'(frame_done), 0);
        send_pixels(16'b11_00_00_00_01_10_10_10, 1, 7);
        check("f2_done", 32'(frame_done), 1);
        check("f2_strong", 32'(strong_count), 1);
        check("f2_weak", 32'(weak_count), 3);
        tick();

        // New thresholds committed at next sof
        start_frame();
        check("f3_t_low", 32'(t_low), 30);
        check("f3_t_high", 32'(t_high), 60);
        write_cfg(50, 10);
        check("f3_cfg_err", 32'(cfg_err), 1);
        tick();
        check("f3_cfg_err_clr", 32'(cfg_err), 0);
        send_pixels(16'h5555, 8, 0);
        check("f3_strong", 32'(strong_count), 8);
        check("f3_weak", 32'(weak_count), 0);
        tick();

        // sof with same-cycle equal-value write: old shadow applies this frame
        cfg_wr = 1'b1; cfg_t_low = 11'd25; cfg_t_high = 11'd25;
        start_frame();
        cfg_wr = 1'b0;
        check("f4_cfg_err", 32'(cfg_err), 0);
        check("f4_t_low", 32'(t_low), 30);
        check("f4_t_high", 32'(t_high), 60);
        send_pixels(16'hAAAA, 8, 0);
        check("f4_weak", 32'(weak_count), 8);
        check("f4_strong", 32'(strong_count), 0);
        tick();
        start_frame();
        check("f5_t_low", 32'(t_low), 25);
        check("f5_t_high", 32'(t_high), 25);

        // Reset after 5 pixels
        send_pixels(16'h5555, 5, 0);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_weak", 32'(weak_count), 0);
        check("mrst_t_low", 32'(t_low), 20);
        check("mrst_t_high", 32'(t_high), 40);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst_done", 32'(frame_done), 0);

        // Clean frame after reset: strong 4, weak 2
        start_frame();
        send_pixels(16'b01_11_01_00_10_01_10_01, 8, 0);
        check("f6_done", 32'(frame_done), 1);
        check("f6_strong", 32'(strong_count), 4);
        check("f6_weak", 32'(weak_count), 2);
        // sof in DONE is rejected and does not start a frame
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("f6_sof_err", 32'(sof_err), 1);
        check("f6_busy_low", 32'(busy), 0);
        tick();
        check("f6_still_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
